// File: rtl/dram_pkg.sv
// Shared types for the DRAM pin-interface initiator: default widths, FSM states
// and the request captured at acceptance.
package dram_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 11;

  typedef enum logic [2:0] {IDLE, ROW, ACT, COL, CAS, PRE} dram_state_e;

  // Field widths follow the package defaults above.
  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] row;
    logic [ADDR_SIZE-1:0] col;
    logic [WORD_SIZE-1:0] wdata;
  } dram_req_t;

endpackage

// File: rtl/dram_ctrl.sv
// Closed-page DRAM initiator: turns one valid/ready request into a
// row-strobe, column-strobe and precharge sequence on the DRAM pins.
//
// state | meaning
// IDLE  | ready for a request, all strobes high, chip deselected
// ROW   | chip selected, row address presented
// ACT   | RASn low, row held
// COL   | column address presented; write data and WEn driven for writes
// CAS   | CASn low for CAS_CYC cycles; read data sampled on the exit edge
// PRE   | precharge with all strobes high for PRE_CYC cycles
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int WORD_SIZE = dram_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = dram_pkg::ADDR_SIZE,
  parameter int CAS_CYC   = 2,
  parameter int PRE_CYC   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  output logic                   resp_valid,
  output logic [WORD_SIZE-1:0]   resp_rdata,
  output logic                   dram_csn,
  output logic                   dram_rasn,
  output logic                   dram_casn,
  output logic                   dram_wen,
  output logic [ADDR_SIZE-1:0]   dram_a,
  output logic [WORD_SIZE-1:0]   dram_d,
  input  logic [WORD_SIZE-1:0]   dram_q
);

  localparam int CNT_MAX = (CAS_CYC > PRE_CYC) ? CAS_CYC : PRE_CYC;
  localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

  dram_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  dram_req_t            req_q, req_nxt;

  logic                 ready_nxt, resp_valid_nxt;
  logic [WORD_SIZE-1:0] rdata_nxt, d_nxt;
  logic                 csn_nxt, rasn_nxt, casn_nxt, wen_nxt;
  logic [ADDR_SIZE-1:0] a_nxt;

  // Every pin is registered, so the output stage shares the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      dram_csn   <= 1'b1;
      dram_rasn  <= 1'b1;
      dram_casn  <= 1'b1;
      dram_wen   <= 1'b1;
      dram_a     <= '0;
      dram_d     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_q      <= req_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= rdata_nxt;
      dram_csn   <= csn_nxt;
      dram_rasn  <= rasn_nxt;
      dram_casn  <= casn_nxt;
      dram_wen   <= wen_nxt;
      dram_a     <= a_nxt;
      dram_d     <= d_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = req_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt     = ROW;
          req_nxt.we    = req_we;
          req_nxt.row   = req_addr[2*ADDR_SIZE-1:ADDR_SIZE];
          req_nxt.col   = req_addr[ADDR_SIZE-1:0];
          req_nxt.wdata = req_wdata;
        end
      end
      ROW: state_nxt = ACT;
      ACT: state_nxt = COL;
      COL: begin
        state_nxt = CAS;
        cnt_nxt   = CNT_W'(CAS_CYC - 1);
      end
      CAS: begin
        if (cnt == '0) begin
          state_nxt = PRE;
          cnt_nxt   = CNT_W'(PRE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PRE: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pin values for the cycle after the coming edge, derived from where the FSM is headed.
  always_comb begin
    ready_nxt      = (state_nxt == IDLE);
    csn_nxt        = (state_nxt == IDLE);
    rasn_nxt       = !(state_nxt inside {ACT, COL, CAS});
    casn_nxt       = (state_nxt != CAS);
    wen_nxt        = !(req_nxt.we && (state_nxt inside {COL, CAS}));
    d_nxt          = (req_nxt.we && (state_nxt inside {COL, CAS})) ? req_nxt.wdata : '0;
    resp_valid_nxt = (state == CAS) && (state_nxt == PRE);
    rdata_nxt      = resp_rdata;
    if ((state == CAS) && (state_nxt == PRE) && !req_q.we) rdata_nxt = dram_q;
    case (state_nxt)
      ROW, ACT: a_nxt = req_nxt.row;
      COL, CAS: a_nxt = req_nxt.col;
      default:  a_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a default instance and a CAS_CYC=4/PRE_CYC=3 instance,
// each wired to a small pin-level DRAM model, checked every cycle against a cycle-count model.
module tb_dram_ctrl;

  logic        clk, rst;
  logic        rv [2];
  logic        rwe [2];
  logic [21:0] raddr [2];
  logic [31:0] rwd [2];
  logic        ready [2];
  logic        rvld [2];
  logic [31:0] rdata [2];
  logic        csn [2];
  logic        rasn [2];
  logic        casn [2];
  logic        wen [2];
  logic [10:0] a [2];
  logic [31:0] d [2];
  logic [31:0] q [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dram_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(ready[0]), .req_we(rwe[0]),
    .req_addr(raddr[0]), .req_wdata(rwd[0]),
    .resp_valid(rvld[0]), .resp_rdata(rdata[0]),
    .dram_csn(csn[0]), .dram_rasn(rasn[0]), .dram_casn(casn[0]), .dram_wen(wen[0]),
    .dram_a(a[0]), .dram_d(d[0]), .dram_q(q[0])
  );

  dram_ctrl #(.CAS_CYC(4), .PRE_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(ready[1]), .req_we(rwe[1]),
    .req_addr(raddr[1]), .req_wdata(rwd[1]),
    .resp_valid(rvld[1]), .resp_rdata(rdata[1]),
    .dram_csn(csn[1]), .dram_rasn(rasn[1]), .dram_casn(casn[1]), .dram_wen(wen[1]),
    .dram_a(a[1]), .dram_d(d[1]), .dram_q(q[1])
  );

  // Pin-level DRAM: row latched on RASn fall, column access while CASn is low,
  // and random garbage on Q at any other time.
  for (genvar g = 0; g < 2; g++) begin : g_dram
    logic [10:0] drow;
    logic [31:0] qv;
    logic [31:0] dmem [logic [21:0]];
    assign q[g] = qv;
    always @(negedge rasn[g]) drow = a[g];
    always @(posedge clk or negedge casn[g]) begin
      if (!casn[g]) begin
        if (!wen[g]) dmem[{drow, a[g]}] = d[g];
        else         qv <= dmem.exists({drow, a[g]}) ? dmem[{drow, a[g]}] : 32'h0;
      end else begin
        qv <= $urandom;
      end
    end
  end

  // Reference model: phase k counts cycles since the accept edge (0 = idle).
  int          cas_c [2] = '{2, 4};
  int          pre_c [2] = '{1, 3};
  int          k [2];
  logic        mwe [2];
  logic [21:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] mmem [logic [22:0]];

  function automatic logic [22:0] mkey(input int i, input logic [21:0] ad);
    return {i[0], ad};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        k[i]         = 0;
        exp_rdata[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (k[i] == 0) begin
          if (rv[i]) begin
            k[i]     = 1;
            mwe[i]   = rwe[i];
            maddr[i] = raddr[i];
            mwd[i]   = rwd[i];
          end
        end else begin
          if (k[i] == 3 + cas_c[i] && !mwe[i])
            exp_rdata[i] = mmem.exists(mkey(i, maddr[i])) ? mmem[mkey(i, maddr[i])] : 32'h0;
          if (k[i] == 3 + cas_c[i] + pre_c[i]) begin
            if (mwe[i]) mmem[mkey(i, maddr[i])] = mwd[i];
            k[i] = 0;
          end else begin
            k[i] = k[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int  kk;
        int  c;
        logic in_row, in_col;
        kk     = k[i];
        c      = cas_c[i];
        in_row = (kk >= 1 && kk <= 2);
        in_col = (kk >= 3 && kk <= 3 + c);
        chk("req_ready", i, ready[i], kk == 0);
        chk("dram_csn", i, csn[i], kk == 0);
        chk("dram_rasn", i, rasn[i], !(kk >= 2 && kk <= 3 + c));
        chk("dram_casn", i, casn[i], !(kk >= 4 && kk <= 3 + c));
        chk("dram_wen", i, wen[i], !(mwe[i] && in_col));
        chk("dram_d", i, d[i], (mwe[i] && in_col) ? mwd[i] : 32'h0);
        chk("resp_valid", i, rvld[i], kk == 4 + c);
        chk("resp_rdata", i, rdata[i], exp_rdata[i]);
        if (kk == 0)     chk("dram_a", i, a[i], 32'h0);
        else if (in_row) chk("dram_a", i, a[i], maddr[i][21:11]);
        else if (in_col) chk("dram_a", i, a[i], maddr[i][10:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return in cycle 1 of the access (one cycle after the accept edge).
  task automatic issue(input int i, input logic we, input logic [21:0] ad, input logic [31:0] wd);
    int n;
    n        = 0;
    rv[i]    = 1'b1;
    rwe[i]   = we;
    raddr[i] = ad;
    rwd[i]   = wd;
    while (!ready[i] && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!ready[i]) begin
      errors++;
      $display("FAIL accept_wait[%0d] got ready=%b expected ready=1 within 50 cycles", i, ready[i]);
    end
    step();
    rv[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0;
    end
    #12;
    chk("rst_ready", 0, ready[0], 1);
    chk("rst_ready", 1, ready[1], 1);
    chk("rst_resp_valid", 0, rvld[0], 0);
    chk("rst_rdata", 0, rdata[0], 0);
    chk("rst_strobes", 0, {csn[0], rasn[0], casn[0], wen[0]}, 4'hF);
    chk("rst_a_d", 0, {a[0], d[0]}, 0);
    rst = 1'b0;
    step();

    // Write row 5 col 10 data 20.
    issue(0, 1'b1, {11'd5, 11'd10}, 32'd20);
    chk("w_c1_a", 0, a[0], 5);
    chk("w_c1_rasn_csn", 0, {rasn[0], csn[0]}, 2'b10);
    step();
    chk("w_c2_rasn", 0, rasn[0], 0);
    step();
    chk("w_c3_a", 0, a[0], 10);
    chk("w_c3_wen", 0, wen[0], 0);
    chk("w_c3_d", 0, d[0], 20);
    step();
    chk("w_c4_casn", 0, casn[0], 0);
    step();
    chk("w_c5_casn", 0, casn[0], 0);
    step();
    chk("w_c6_strobes", 0, {rasn[0], casn[0], wen[0]}, 3'b111);
    chk("w_c6_resp_valid", 0, rvld[0], 1);
    step();
    chk("w_c7_ready", 0, ready[0], 1);

    // Read it back.
    issue(0, 1'b0, {11'd5, 11'd10}, 32'h0);
    repeat (5) step();
    chk("r_c6_resp_valid", 0, rvld[0], 1);
    chk("r_c6_rdata", 0, rdata[0], 20);
    step();

    // Back-to-back with req_valid held: write then read of {1,2}.
    rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = {11'd1, 11'd2}; rwd[0] = 32'hA5A5_0001;
    step();
    rwe[0] = 1'b0;
    repeat (5) step();
    chk("b2b_c6_ready", 0, ready[0], 0);
    step();
    chk("b2b_c7_ready", 0, ready[0], 1);
    chk("b2b_c7_csn", 0, csn[0], 1);
    step();
    chk("b2b_c8_ready", 0, ready[0], 0);
    chk("b2b_c8_csn", 0, csn[0], 0);
    chk("b2b_c8_a", 0, a[0], 1);
    rv[0] = 1'b0;
    repeat (5) step();
    chk("b2b_rd_resp_valid", 0, rvld[0], 1);
    chk("b2b_rd_rdata", 0, rdata[0], 32'hA5A5_0001);
    step();

    // Reset in the middle of CAS of a write.
    issue(0, 1'b1, {11'd5, 11'd10}, 32'd20);
    repeat (3) step();
    chk("abort_c4_casn", 0, casn[0], 0);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobes", 0, {csn[0], rasn[0], casn[0], wen[0]}, 4'hF);
    chk("abort_ready", 0, ready[0], 1);
    chk("abort_resp_valid", 0, rvld[0], 0);
    chk("abort_rdata", 0, rdata[0], 0);
    chk("abort_a_d", 0, {a[0], d[0]}, 0);
    #1 rst = 1'b0;
    issue(0, 1'b0, {11'd5, 11'd10}, 32'h0);
    repeat (5) step();
    chk("post_abort_resp_valid", 0, rvld[0], 1);
    chk("post_abort_rdata", 0, rdata[0], 20);
    step();

    // Longer CAS and precharge on the second instance.
    issue(1, 1'b1, {11'd3, 11'd4}, 32'h0000_1234);
    repeat (3) step();
    chk("l_c4_casn", 1, casn[1], 0);
    repeat (3) step();
    chk("l_c7_casn", 1, casn[1], 0);
    chk("l_c7_resp_valid", 1, rvld[1], 0);
    step();
    chk("l_c8_casn", 1, casn[1], 1);
    chk("l_c8_resp_valid", 1, rvld[1], 1);
    step();
    chk("l_c9_resp_valid", 1, rvld[1], 0);
    chk("l_c9_csn", 1, csn[1], 0);
    step();
    chk("l_c10_ready", 1, ready[1], 0);
    step();
    chk("l_c11_ready", 1, ready[1], 1);
    issue(1, 1'b0, {11'd3, 11'd4}, 32'h0);
    repeat (7) step();
    chk("l_rd_resp_valid", 1, rvld[1], 1);
    chk("l_rd_rdata", 1, rdata[1], 32'h0000_1234);
    step();

    // All-ones row and column.
    issue(0, 1'b1, {11'h7FF, 11'h7FF}, 32'hFFFF_FFFF);
    chk("ones_w_row", 0, a[0], 11'h7FF);
    repeat (2) step();
    chk("ones_w_col", 0, a[0], 11'h7FF);
    repeat (4) step();
    issue(0, 1'b0, {11'h7FF, 11'h7FF}, 32'h0);
    chk("ones_r_row", 0, a[0], 11'h7FF);
    repeat (2) step();
    chk("ones_r_col", 0, a[0], 11'h7FF);
    repeat (3) step();
    chk("ones_r_resp_valid", 0, rvld[0], 1);
    chk("ones_r_rdata", 0, rdata[0], 32'hFFFF_FFFF);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Initiator side of the asynchronous-strobe DRAM pin interface (CSn/RASn/CASn/WEn/A/D/Q).
- Converts single-word read/write requests from a valid/ready port into the row-strobe / column-strobe / precharge sequence the DRAM model expects.
- Sits between the system bus wrapper and the DRAM model.
- Closed-page policy: one access per request, no bursts, no refresh.

Parameters:
- WORD_SIZE, 32, data width.
- ADDR_SIZE, 11, DRAM address pin width; row and column are ADDR_SIZE bits each.
- CAS_CYC, 2, cycles CASn is held low (>=1).
- PRE_CYC, 1, precharge cycles with all strobes high (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  2*ADDR_SIZE  {row, col}; row in the upper half.
- req_wdata  in  WORD_SIZE  write data.
- resp_valid  out  1  one-cycle pulse: access complete; read data valid.
- resp_rdata  out  WORD_SIZE  read data, held until the next read completes.
- dram_csn  out  1  chip select, active low.
- dram_rasn  out  1  row address strobe, active low.
- dram_casn  out  1  column address strobe, active low.
- dram_wen  out  1  write enable, active low.
- dram_a  out  ADDR_SIZE  multiplexed row/column address.
- dram_d  out  WORD_SIZE  write data to DRAM.
- dram_q  in  WORD_SIZE  read data from DRAM.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0
  - dram_csn=1, dram_rasn=1, dram_casn=1, dram_wen=1
  - dram_a=0, dram_d=0
- FSM states: IDLE, ROW, ACT, COL, CAS, PRE.
- IDLE:
  - req_ready=1; strobes high; dram_a=0; dram_d=0.
  - On req_valid&req_ready, latch we/addr/wdata and go to ROW; req_ready drops the same edge.
- ROW (1 cycle): csn=0, dram_a=row, rasn=1.
- ACT (1 cycle): rasn=0, dram_a=row.
- COL (1 cycle):
  - dram_a=col, rasn=0.
  - Write: wen=0, dram_d=wdata.
  - Read: wen=1, dram_d=0.
- CAS (CAS_CYC cycles):
  - casn=0; dram_a, wen and dram_d held from COL.
  - Down-counter loaded with CAS_CYC-1 on entry.
  - For a read, resp_rdata<=dram_q on the edge leaving CAS.
- PRE (PRE_CYC cycles):
  - rasn=casn=wen=1, dram_d=0; csn stays 0.
  - resp_valid=1 in the first PRE cycle only.
  - Go to IDLE on counter expiry; csn=1 and req_ready=1 on entry to IDLE.
- Latency with defaults:
  - Accept edge (cycle 0), then ROW=1, ACT=2, COL=3, CAS=4-5, PRE=6, IDLE/ready=7.
  - Back-to-back throughput: one access per 7 cycles.
- Writes also return resp_valid; resp_rdata is unchanged by a write.
- req_valid while busy is ignored (ready=0). The requester holds it and is accepted in IDLE.
- rst asserted mid-access: all outputs go to reset values immediately, FSM goes to IDLE, the latched request is discarded, no resp_valid.
- Address 0 and all-ones row/col need no special handling.
- Changes of dram_q outside the CAS sampling edge have no effect.

Decomposition:
- dram_pkg holds:
  - WORD_SIZE and ADDR_SIZE defaults
  - dram_state_e enum {IDLE, ROW, ACT, COL, CAS, PRE}
  - a packed struct for the latched request {we, row, col, wdata}
- No sub-module. The FSM plus one shared phase down-counter is a single module.

Test Plan:
- Write row 5 col 10 data 20 (addr {5,10}) -> cycle 1: A=5, RASn=1; cycle 2: RASn=0; cycle 3: A=10, WEn=0, D=20; cycles 4-5: CASn=0; cycle 6: all strobes high, resp_valid=1; cycle 7: req_ready=1.
- Read addr {5,10} after that write -> WEn stays 1 throughout; resp_rdata=20 with resp_valid at cycle 6.
- Two back-to-back requests with req_valid held high -> second accepted exactly at cycle 7; no strobe overlap; CSn high for exactly the IDLE cycle.
- rst pulsed during CAS of a write -> all strobes high and CSn=1 with no clock edge; no resp_valid; a following read of the same address completes normally.
- CAS_CYC=4, PRE_CYC=3 -> CASn low exactly 4 cycles, PRE lasts 3 cycles, resp_valid at cycle 8, ready at cycle 11.
- Write {2047,2047} data 32'hFFFF_FFFF, then read it back -> A=11'h7FF in both row and column phases; resp_rdata=32'hFFFF_FFFF.
